// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: read-priority memory command arbiter with outstanding-read tracking.
// Define MEM_ARB_FAIRNESS_EN to let a waiting write break long read streaks.
module mem_port_arbiter #(
  parameter int ADDRESS_WIDTH   = 25,
  parameter int DATA_WIDTH      = 16,
  parameter int RD_STARVE_LIMIT = 8,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [ADDRESS_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     rd_valid,
  output logic                     rd_ready,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     rd_data_valid,
  output logic [ADDRESS_WIDTH-1:0] address_mem,
  output logic                     wr_mem,
  output logic [DATA_WIDTH-1:0]    data_out_mem,
  output logic                     data_out_ready_mem,
  input  logic                     fifo_full_mem,
  input  logic [DATA_WIDTH-1:0]    data_in_mem,
  input  logic                     data_in_ready_mem,
  output logic [3:0]               outstanding,
  output logic                     rd_overflow_err
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RD    = 2'd1;
  localparam logic [1:0] WR    = 2'd2;
  localparam logic [1:0] STALL = 2'd3;

  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 15 || RD_STARVE_LIMIT < 1) begin : g_bad_param
    $error("mem_port_arbiter: illegal parameter value");
  end

  logic [1:0]               state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] address_q, address_d;
  logic                     wr_mem_q, wr_mem_d;
  logic [DATA_WIDTH-1:0]    data_out_q, data_out_d;
  logic [3:0]               outstanding_q, outstanding_d;
  logic                     err_q, err_d;
  logic [DATA_WIDTH-1:0]    rd_data_q, rd_data_d;
  logic                     rd_dv_q;
  logic                     force_wr, full_os, ret_ok, issue;

`ifdef MEM_ARB_FAIRNESS_EN
  localparam int SW = $clog2(RD_STARVE_LIMIT + 1);
  logic [SW-1:0] rd_streak_q, rd_streak_d;
  assign force_wr    = wr_valid && rd_streak_q == SW'(RD_STARVE_LIMIT);
  assign rd_streak_d = (wr_ready || !wr_valid) ? '0 : rd_ready ? rd_streak_q + 1'b1 : rd_streak_q;
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) rd_streak_q <= '0;
    else rd_streak_q <= rd_streak_d;
`else
  assign force_wr = 1'b0;
`endif

  assign full_os  = outstanding_q == 4'(MAX_OUTSTANDING);
  assign rd_ready = !fifo_full_mem && rd_valid && !full_os && !force_wr;
  assign wr_ready = !fifo_full_mem && wr_valid && !rd_ready;
  assign issue    = rd_ready || wr_ready;
  // A return with nothing in flight is spurious and must not be forwarded.
  assign ret_ok   = data_in_ready_mem && outstanding_q != 4'd0;

  always_comb begin
    address_d     = issue ? (rd_ready ? rd_addr : wr_addr) : address_q;
    wr_mem_d      = issue ? wr_ready : wr_mem_q;
    data_out_d    = wr_ready ? wr_data : data_out_q;
    outstanding_d = outstanding_q + 4'(rd_ready) - 4'(ret_ok);
    err_d         = err_q || (data_in_ready_mem && !ret_ok);
    rd_data_d     = ret_ok ? data_in_mem : rd_data_q;
    state_d       = rd_ready ? RD : wr_ready ? WR :
                    (fifo_full_mem && (wr_valid || rd_valid)) ? STALL : IDLE;
  end

  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      state_q       <= IDLE;
      address_q     <= '0;
      wr_mem_q      <= 1'b0;
      data_out_q    <= '0;
      outstanding_q <= 4'd0;
      err_q         <= 1'b0;
      rd_data_q     <= '0;
      rd_dv_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      address_q     <= address_d;
      wr_mem_q      <= wr_mem_d;
      data_out_q    <= data_out_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
      rd_data_q     <= rd_data_d;
      rd_dv_q       <= ret_ok;
    end

  // The command strobe is exactly "an issue happened last edge", which the state encodes.
  assign data_out_ready_mem = state_q == RD || state_q == WR;
  assign address_mem        = address_q;
  assign wr_mem             = wr_mem_q;
  assign data_out_mem       = data_out_q;
  assign outstanding        = outstanding_q;
  assign rd_overflow_err    = err_q;
  assign rd_data            = rd_data_q;
  assign rd_data_valid      = rd_dv_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for mem_port_arbiter.
module tb_mem_port_arbiter;
`ifdef MEM_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif
  localparam int LIMIT = 8;

  typedef struct packed {
    logic        wr;
    logic [24:0] addr;
    logic [15:0] data;
  } cmd_t;

  logic        clk_sys = 1'b0, reset = 1'b1;
  logic        wr_valid = 1'b0, rd_valid = 1'b0, wr_ready, rd_ready;
  logic [24:0] wr_addr = '0, rd_addr = '0, address_mem;
  logic [15:0] wr_data = '0, rd_data, data_out_mem, data_in_mem = '0;
  logic        rd_data_valid, wr_mem, data_out_ready_mem, rd_overflow_err;
  logic        fifo_full_mem = 1'b0, data_in_ready_mem = 1'b0;
  logic [3:0]  outstanding;

  cmd_t        cmd_q[$];
  logic [15:0] ret_q[$];
  cmd_t        mon_e;
  logic [15:0] mon_r;
  logic [15:0] last_wr = '0;
  int          n_chk = 0, n_fail = 0, n_rd_seen = 0, n_wr_seen = 0;
  int          base_rd, base_wr, streak;
  bit          g_wr;

  mem_port_arbiter dut (
    .clk_sys(clk_sys), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .address_mem(address_mem), .wr_mem(wr_mem), .data_out_mem(data_out_mem),
    .data_out_ready_mem(data_out_ready_mem), .fifo_full_mem(fifo_full_mem),
    .data_in_mem(data_in_mem), .data_in_ready_mem(data_in_ready_mem),
    .outstanding(outstanding), .rd_overflow_err(rd_overflow_err)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic push_rd(input logic [24:0] a);
    cmd_q.push_back({1'b0, a, last_wr});
  endtask

  task automatic push_wr(input logic [24:0] a, input logic [15:0] d);
    cmd_q.push_back({1'b1, a, d});
    last_wr = d;
  endtask

  // Scoreboard: every command or read return the DUT produces must match the next expectation.
  always @(negedge clk_sys)
    if (!reset) begin
      if (data_out_ready_mem) begin
        if (wr_mem) n_wr_seen++;
        else n_rd_seen++;
        if (cmd_q.size() == 0) chk("cmd_unexpected", data_out_ready_mem, 0);
        else begin
          mon_e = cmd_q.pop_front();
          chk("cmd_wr", wr_mem, mon_e.wr);
          chk("cmd_addr", address_mem, mon_e.addr);
          chk("cmd_data", data_out_mem, mon_e.data);
        end
      end
      if (rd_data_valid) begin
        if (ret_q.size() == 0) chk("ret_unexpected", rd_data_valid, 0);
        else begin
          mon_r = ret_q.pop_front();
          chk("ret_data", rd_data, mon_r);
        end
      end
    end

  initial begin
    #3;
    chk("rst_outstanding", outstanding, 0);
    chk("rst_dor", data_out_ready_mem, 0);
    chk("rst_addr", address_mem, 0);
    chk("rst_err", rd_overflow_err, 0);
    chk("rst_rdv", rd_data_valid, 0);
    chk("rst_state", dut.state_q, 0);
    @(negedge clk_sys) reset = 1'b0;
    tick();
    // single write
    wr_valid = 1'b1; wr_addr = 25'h100; wr_data = 16'hABCD;
    #1;
    chk("w_wr_ready", wr_ready, 1);
    chk("w_rd_ready", rd_ready, 0);
    push_wr(25'h100, 16'hABCD);
    tick();
    wr_valid = 1'b0;
    chk("w_pulse", data_out_ready_mem, 1);
    chk("w_addr", address_mem, 25'h100);
    chk("w_data", data_out_mem, 16'hABCD);
    chk("w_wrmem", wr_mem, 1);
    tick();
    chk("w_pulse_end", data_out_ready_mem, 0);
    chk("w_addr_hold", address_mem, 25'h100);
    // arbitration with both valids held for 20 cycles, returns served promptly
    base_rd = n_rd_seen; base_wr = n_wr_seen; streak = 0;
    for (int i = 0; i < 20; i++) begin
      rd_valid = 1'b1; wr_valid = 1'b1;
      rd_addr = 25'h200 + 25'(i); wr_addr = 25'h300; wr_data = 16'h1234;
      data_in_ready_mem = data_out_ready_mem && !wr_mem;
      data_in_mem = 16'h5000 + 16'(i);
      if (data_in_ready_mem) ret_q.push_back(data_in_mem);
      #1;
      g_wr = FAIR && streak == LIMIT;
      chk("arb_rd_ready", rd_ready, !g_wr);
      chk("arb_wr_ready", wr_ready, g_wr);
      if (g_wr) begin push_wr(25'h300, 16'h1234); streak = 0; end
      else begin push_rd(rd_addr); streak++; end
      tick();
    end
    rd_valid = 1'b0; wr_valid = 1'b0;
    data_in_ready_mem = data_out_ready_mem && !wr_mem;
    data_in_mem = 16'h5555;
    if (data_in_ready_mem) ret_q.push_back(data_in_mem);
    tick();
    data_in_ready_mem = 1'b0;
    tick();
    chk("arb_reads", n_rd_seen - base_rd, FAIR ? 18 : 20);
    chk("arb_writes", n_wr_seen - base_wr, FAIR ? 2 : 0);
    chk("arb_outstanding", outstanding, 0);
    // back-pressure stall
    fifo_full_mem = 1'b1; rd_valid = 1'b1; wr_valid = 1'b1; rd_addr = 25'h444;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_rd_ready", rd_ready, 0);
      chk("stall_wr_ready", wr_ready, 0);
      tick();
      chk("stall_state", dut.state_q, 3);
    end
    fifo_full_mem = 1'b0;
    #1;
    chk("release_rd_ready", rd_ready, 1);
    push_rd(25'h444);
    tick();
    rd_valid = 1'b0; wr_valid = 1'b0;
    chk("release_pulse", data_out_ready_mem, 1);
    data_in_ready_mem = 1'b1; data_in_mem = 16'h4444; ret_q.push_back(16'h4444);
    tick();
    data_in_ready_mem = 1'b0;
    chk("release_rdv", rd_data_valid, 1);
    chk("release_outstanding", outstanding, 0);
    // fill to MAX_OUTSTANDING
    rd_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd_addr = 25'h500 + 25'(i);
      #1;
      chk("fill_rd_ready", rd_ready, 1);
      push_rd(rd_addr);
      tick();
    end
    rd_addr = 25'h508;
    #1;
    chk("full_outstanding", outstanding, 8);
    chk("full_rd_ready", rd_ready, 0);
    chk("full_wr_ready", wr_ready, 0);
    data_in_ready_mem = 1'b1; data_in_mem = 16'h7777; ret_q.push_back(16'h7777);
    tick();
    data_in_ready_mem = 1'b0;
    #1;
    chk("ret_rdv", rd_data_valid, 1);
    chk("ret_rd_data", rd_data, 16'h7777);
    chk("ret_outstanding", outstanding, 7);
    chk("ninth_rd_ready", rd_ready, 1);
    push_rd(25'h508);
    tick();
    rd_valid = 1'b0;
    chk("ninth_addr", address_mem, 25'h508);
    chk("ninth_outstanding", outstanding, 8);
    // drain to 3, then issue and return together
    for (int i = 0; i < 5; i++) begin
      data_in_ready_mem = 1'b1; data_in_mem = 16'h6000 + 16'(i); ret_q.push_back(data_in_mem);
      tick();
    end
    data_in_ready_mem = 1'b0;
    chk("drain_outstanding", outstanding, 3);
    rd_valid = 1'b1; rd_addr = 25'h600;
    data_in_ready_mem = 1'b1; data_in_mem = 16'h6100; ret_q.push_back(16'h6100);
    push_rd(25'h600);
    tick();
    rd_valid = 1'b0; data_in_ready_mem = 1'b0;
    chk("same_cycle_outstanding", outstanding, 3);
    // reset in the middle of a burst
    rd_valid = 1'b1; rd_addr = 25'h700; push_rd(25'h700);
    tick();
    rd_addr = 25'h701; push_rd(25'h701);
    tick();
    rd_valid = 1'b0;
    chk("burst_outstanding", outstanding, 5);
    #6;
    reset = 1'b1;
    #1;
    chk("async_outstanding", outstanding, 0);
    chk("async_addr", address_mem, 0);
    chk("async_data", data_out_mem, 0);
    chk("async_rd_data", rd_data, 0);
    chk("async_wrmem", wr_mem, 0);
    ret_q.delete();
    last_wr = '0;
    @(negedge clk_sys) reset = 1'b0;
    tick();
    // spurious return
    data_in_ready_mem = 1'b1; data_in_mem = 16'hDEAD;
    tick();
    data_in_ready_mem = 1'b0;
    chk("ovf_err", rd_overflow_err, 1);
    chk("ovf_rdv", rd_data_valid, 0);
    chk("ovf_outstanding", outstanding, 0);
    tick();
    tick();
    chk("ovf_sticky", rd_overflow_err, 1);
    chk("cmd_q_empty", cmd_q.size(), 0);
    chk("ret_q_empty", ret_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters (name, default, meaning): ADDRESS_WIDTH, 25, memory word address width; DATA_WIDTH, 16, memory word width; RD_STARVE_LIMIT, 8, consecutive read issues allowed while a write waits; MAX_OUTSTANDING, 8, reads in flight, 1..15.
REQ-002 clk_sys  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 wr_valid / wr_ready  input / output  1 / 1  write request handshake from the host command path.
REQ-005 wr_addr / wr_data  input  ADDRESS_WIDTH / DATA_WIDTH  write address and data, qualified by wr_valid.
REQ-006 rd_valid / rd_ready  input / output  1 / 1  read request handshake from the display scan path.
REQ-007 rd_addr  input  ADDRESS_WIDTH  read address, qualified by rd_valid.
REQ-008 rd_data / rd_data_valid  output  DATA_WIDTH / 1  returned read word and its one-cycle strobe.
REQ-009 address_mem, wr_mem, data_out_mem, data_out_ready_mem  output  ADDRESS_WIDTH, 1, DATA_WIDTH, 1  command to memory; data_out_ready_mem strobes one command.
REQ-010 fifo_full_mem  input  1  memory back-pressure; no command is issued while it is high.
REQ-011 data_in_mem / data_in_ready_mem  input  DATA_WIDTH / 1  read return word and strobe from memory.
REQ-012 outstanding  output  4  reads issued but not yet returned.
REQ-013 rd_overflow_err  output  1  sticky flag: a return arrived with outstanding == 0.

Function
REQ-014 The request ready signals SHALL be combinational from the state, the counters, fifo_full_mem and the valid signals; at most one of wr_ready and rd_ready is high in any cycle.
REQ-015 Both ready signals SHALL be 0 while fifo_full_mem = 1.
REQ-016 rd_ready SHALL be 0 while outstanding == MAX_OUTSTANDING.
REQ-017 Default priority is read over write, because display refresh is real-time.
REQ-018 An accepted request (valid & ready) SHALL drive address_mem, wr_mem (1 for write, 0 for read), data_out_mem (wr_data for a write, hold value for a read) and data_out_ready_mem = 1 on the next edge.
- Latency: 1 cycle.
- data_out_ready_mem is high for exactly one cycle per accepted request; otherwise 0.
- address_mem, wr_mem and data_out_mem hold their values when no command is issued.
REQ-019 State machine, with the state updated every edge:
- IDLE: nothing issued.
- RD: a read was issued this edge.
- WR: a write was issued this edge.
- STALL: fifo_full_mem = 1 while any valid is high.
- From any state: next state = RD, WR, STALL or IDLE per the accepted request or the stall condition.
REQ-020 outstanding SHALL increment on a read issue and decrement on data_in_ready_mem.
- Both in the same cycle: unchanged.
- outstanding SHALL never wrap.
REQ-021 Each data_in_ready_mem with outstanding > 0 SHALL produce rd_data = data_in_mem and rd_data_valid = 1 one cycle later.
REQ-022 A return with outstanding == 0 SHALL be dropped (no rd_data_valid), SHALL set rd_overflow_err, and SHALL leave outstanding at 0.
REQ-023 Returns SHALL be forwarded regardless of fifo_full_mem and the request arbitration.

Reset
REQ-024 Asserting reset SHALL immediately force the following, independent of clk_sys:
- state = IDLE;
- outstanding = 0; rd_streak = 0; rd_overflow_err = 0;
- address_mem = 0; data_out_mem = 0; rd_data = 0;
- wr_mem = 0; data_out_ready_mem = 0; rd_data_valid = 0.
REQ-025 Reset mid-operation SHALL abandon in-flight reads; returns arriving after release with outstanding == 0 follow REQ-022.

Configuration
REQ-026 Macro MEM_ARB_FAIRNESS_EN defined: a counter rd_streak SHALL count reads issued while wr_valid = 1.
- rd_streak clears on any write issue, or on any cycle with wr_valid = 0.
- When rd_streak == RD_STARVE_LIMIT, the next grant SHALL go to the write if wr_valid = 1.
REQ-027 Macro MEM_ARB_FAIRNESS_EN undefined: strict read priority; rd_streak logic is absent; writes wait until rd_valid = 0 or rd_ready = 0.

Verification
REQ-028 wr_valid = 1, wr_addr = 0x100, wr_data = 0xABCD, rd_valid = 0 -> next cycle address_mem = 0x100, data_out_mem = 0xABCD, wr_mem = 1, data_out_ready_mem = 1 for one cycle.
REQ-029 rd_valid and wr_valid both held at 1 for 20 cycles, fairness enabled, limit 8 -> 8 reads, 1 write, 8 reads, 1 write, 2 reads; disabled -> 20 reads and 0 writes.
REQ-030 fifo_full_mem = 1 for 5 cycles with both valids high -> no data_out_ready_mem pulse, state = STALL, both readies 0; the first issue comes the cycle after release.
REQ-031 9 reads requested with no returns, MAX_OUTSTANDING = 8 -> outstanding = 8, rd_ready = 0; one return -> rd_data_valid pulse with the matching data, and the 9th read issues.
REQ-032 data_in_ready_mem pulse with outstanding = 0 -> rd_overflow_err = 1 and stays 1, no rd_data_valid; reset asserted mid-burst with outstanding = 5 -> outstanding = 0 at once.
REQ-033 Read issue and read return in the same cycle with outstanding = 3 -> outstanding stays 3.
